me_sched_ctrl: RTL and testbench



---
 rtl/me_sched_ctrl_if.sv | 41 ++++
 rtl/me_sched_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_me_sched_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/me_sched_ctrl_if.sv
// Control/address bundle between the motion-estimation schedule controller
// (master) and the SAD datapath with its memories (slave).
interface me_sched_ctrl_if #(
   parameter int BLK_SIZE   = 16,
   parameter int SRCH_RANGE = 16
);
   localparam int W     = BLK_SIZE + SRCH_RANGE - 1;
   localparam int RB_AW = $clog2(BLK_SIZE * BLK_SIZE);
   localparam int SW_AW = $clog2(W * W);
   localparam int VW    = (SRCH_RANGE > 1) ? $clog2(SRCH_RANGE) : 1;

   logic                  in_start;
   logic                  in_stall;
   logic                  in_abort;
   logic                  out_busy;
   logic                  out_done;
   logic                  out_addr_valid;
   logic [RB_AW-1:0]      out_rb_read_addr;
   logic [SW_AW-1:0]      out_sw_read_addr1;
   logic [SW_AW-1:0]      out_sw_read_addr2;
   logic [SRCH_RANGE-1:0] out_pe_ena;
   logic [SRCH_RANGE-1:0] out_sw_mux;
   logic [VW-1:0]         out_vec_v;
   logic                  out_pass_end;

   // Handshake: in_start is a level sampled only while idle; in_stall freezes
   // a running search for every cycle it is high; in_abort cancels at once.
   modport master (
      input  in_start, in_stall, in_abort,
      output out_busy, out_done, out_addr_valid, out_rb_read_addr,
             out_sw_read_addr1, out_sw_read_addr2, out_pe_ena, out_sw_mux,
             out_vec_v, out_pass_end
   );

   modport slave (
      output in_start, in_stall, in_abort,
      input  out_busy, out_done, out_addr_valid, out_rb_read_addr,
             out_sw_read_addr1, out_sw_read_addr2, out_pe_ena, out_sw_mux,
             out_vec_v, out_pass_end
   );
endinterface

// File: rtl/me_sched_ctrl.sv
// Full-search block-matching schedule controller: walks row/column/vertical
// candidate indices and issues memory addresses, PE enables and source selects.
module me_sched_ctrl #(
   parameter int BLK_SIZE   = 16,
   parameter int SRCH_RANGE = 16,
   parameter int MEM_LAT    = 1
) (
   input  logic            in_clk,
   input  logic            in_rst,
   me_sched_ctrl_if.master bus,
   output logic [1:0]      dbg_state
);
   localparam int N         = BLK_SIZE;
   localparam int R         = SRCH_RANGE;
   localparam int W         = N + R - 1;
   localparam int RB_AW     = $clog2(N * N);
   localparam int SW_AW     = $clog2(W * W);
   localparam int VW        = (R > 1) ? $clog2(R) : 1;
   localparam int CW        = (N > 1) ? $clog2(N) : 1;
   localparam int DL_W      = MEM_LAT + R - 1;
   localparam int DRAIN_LEN = MEM_LAT + R - 1;
   localparam int DCW       = $clog2(DRAIN_LEN + 1);

   // dbg_state encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             freeze;
   logic             last_idx;

   logic [CW-1:0]    r_q, r_d, c_q, c_d;
   logic [VW-1:0]    v_q, v_d;
   logic [DCW-1:0]   drain_q, drain_d;
   logic [DL_W-1:0]  dl_q, dl_d;

   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [RB_AW-1:0] rb_q, rb_d;
   logic [SW_AW-1:0] sw1_q, sw1_d, sw2_q, sw2_d;
   logic [R-1:0]     mux_q, mux_d;
   logic [VW-1:0]    vec_q, vec_d;
   logic             pend_q, pend_d;

   int               rb_i, sw1_i, sw2_i;

   assign last_idx = (r_q == CW'(N - 1)) && (c_q == CW'(N - 1)) && (v_q == VW'(R - 1));

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      freeze  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_start) state_d = S_RUN;
         end
         S_RUN: begin
            if (bus.in_stall)  freeze  = 1'b1;
            else if (last_idx) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (bus.in_stall) freeze = 1'b1;
            else if (drain_q == DCW'(DRAIN_LEN - 1)) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort outranks both stall and start from any active state.
      if (bus.in_abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         freeze  = 1'b0;
      end
   end

   // Index stream: r fastest, then c, then v; counters rest at zero outside RUN.
   always_comb begin
      r_d     = '0;
      c_d     = '0;
      v_d     = '0;
      valid_d = 1'b0;
      if ((state_q == S_IDLE) && (state_d == S_RUN)) begin
         valid_d = 1'b1;
      end else if ((state_q == S_RUN) && (state_d == S_RUN)) begin
         valid_d = 1'b1;
         r_d     = r_q;
         c_d     = c_q;
         v_d     = v_q;
         if (!freeze) begin
            if (r_q == CW'(N - 1)) begin
               r_d = '0;
               if (c_q == CW'(N - 1)) begin
                  c_d = '0;
                  v_d = v_q + 1'b1;
               end else begin
                  c_d = c_q + 1'b1;
               end
            end else begin
               r_d = r_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      drain_d = '0;
      if (state_d == S_DRAIN) begin
         drain_d = drain_q;
         if ((state_q == S_DRAIN) && !freeze) drain_d = drain_q + 1'b1;
      end

      // MEM_LAT-1 hidden stages, then one stage per PE; out_pe_ena is the top R bits.
      if (state_d == S_IDLE) dl_d = '0;
      else if (freeze)       dl_d = dl_q;
      else                   dl_d = (dl_q << 1) | DL_W'(valid_q);
   end

   // Outputs describe the index that will be on the bus after this edge.
   always_comb begin
      rb_i   = int'(r_d) * N + int'(c_d);
      sw1_i  = (int'(v_d) + int'(r_d)) * W + int'(c_d);
      sw2_i  = sw1_i + R - 1;
      rb_d   = valid_d ? RB_AW'(rb_i)  : '0;
      sw1_d  = valid_d ? SW_AW'(sw1_i) : '0;
      sw2_d  = valid_d ? SW_AW'(sw2_i) : '0;
      vec_d  = valid_d ? v_d : '0;
      pend_d = valid_d && (r_d == CW'(N - 1)) && (c_d == CW'(N - 1));
      mux_d  = '0;
      for (int j = 0; j < R; j++) mux_d[j] = valid_d && (int'(r_d) >= j);
      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         r_q     <= '0;
         c_q     <= '0;
         v_q     <= '0;
         drain_q <= '0;
         dl_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rb_q    <= '0;
         sw1_q   <= '0;
         sw2_q   <= '0;
         mux_q   <= '0;
         vec_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         r_q     <= r_d;
         c_q     <= c_d;
         v_q     <= v_d;
         drain_q <= drain_d;
         dl_q    <= dl_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rb_q    <= rb_d;
         sw1_q   <= sw1_d;
         sw2_q   <= sw2_d;
         mux_q   <= mux_d;
         vec_q   <= vec_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.out_busy          = busy_q;
   assign bus.out_done          = done_q;
   assign bus.out_addr_valid    = valid_q;
   assign bus.out_rb_read_addr  = rb_q;
   assign bus.out_sw_read_addr1 = sw1_q;
   assign bus.out_sw_read_addr2 = sw2_q;
   assign bus.out_pe_ena        = dl_q[DL_W-1:MEM_LAT-1];
   assign bus.out_sw_mux        = mux_q;
   assign bus.out_vec_v         = vec_q;
   assign bus.out_pass_end      = pend_q;
   assign dbg_state             = state_q;
endmodule

// File: tb/tb_me_sched_ctrl.sv
// Bench for me_sched_ctrl: default 16x16 instance with random stalls, abort and
// async reset, plus an 8x8 instance for the parameter override timing.
module tb_me_sched_ctrl;
   localparam int N  = 16, R  = 16, M  = 1;
   localparam int N8 = 8,  R8 = 8,  M8 = 1;
   localparam int TOTAL16 = R * N * N;
   localparam int LAST16  = TOTAL16 + M + R - 1;
   localparam int LAST8   = R8 * N8 * N8 + M8 + R8 - 1;

   typedef struct packed {
      logic [1:0]  st;
      logic        busy, done, valid, pend;
      logic [31:0] rb, sw1, sw2, pe, mux, vv;
   } snap_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   me_sched_ctrl_if #(.BLK_SIZE(N),  .SRCH_RANGE(R))  bus16 ();
   me_sched_ctrl_if #(.BLK_SIZE(N8), .SRCH_RANGE(R8)) bus8 ();
   logic [1:0] st16, st8;

   me_sched_ctrl #(.BLK_SIZE(N), .SRCH_RANGE(R), .MEM_LAT(M)) u_dut (
      .in_clk(clk), .in_rst(rst), .bus(bus16), .dbg_state(st16));
   me_sched_ctrl #(.BLK_SIZE(N8), .SRCH_RANGE(R8), .MEM_LAT(M8)) u_dut8 (
      .in_clk(clk), .in_rst(rst), .bus(bus8), .dbg_state(st8));

   snap_t o16, o8;
   always_comb begin
      o16 = '0;
      o16.st = st16; o16.busy = bus16.out_busy; o16.done = bus16.out_done;
      o16.valid = bus16.out_addr_valid; o16.pend = bus16.out_pass_end;
      o16.rb = 32'(bus16.out_rb_read_addr); o16.sw1 = 32'(bus16.out_sw_read_addr1);
      o16.sw2 = 32'(bus16.out_sw_read_addr2); o16.pe = 32'(bus16.out_pe_ena);
      o16.mux = 32'(bus16.out_sw_mux); o16.vv = 32'(bus16.out_vec_v);
   end
   always_comb begin
      o8 = '0;
      o8.st = st8; o8.busy = bus8.out_busy; o8.done = bus8.out_done;
      o8.valid = bus8.out_addr_valid; o8.pend = bus8.out_pass_end;
      o8.rb = 32'(bus8.out_rb_read_addr); o8.sw1 = 32'(bus8.out_sw_read_addr1);
      o8.sw2 = 32'(bus8.out_sw_read_addr2); o8.pe = 32'(bus8.out_pe_ena);
      o8.mux = 32'(bus8.out_sw_mux); o8.vv = 32'(bus8.out_vec_v);
   end

   int n_assert = 0, n_fail = 0;
   int cyc = 0;
   bit act16 = 0, act8 = 0;
   int u16 = 0, u8 = 0;
   int dir_left = 0, rnd_stalls = 0;
   int done16_cyc = -1, done8_cyc = -1, done16_cnt = 0, last_idx_cyc = -1;
   int max_sw2_8 = 0;

   // Expected outputs after u unstalled edges since the start edge, derived from
   // the index decomposition k -> (v, c, r) and the enable delay-line timing.
   function automatic snap_t expect_snap(input int n, input int r, input int m,
                                         input bit act, input int u);
      snap_t s;
      int total, w, kr, kc, kv;
      s = '0;
      total = r * n * n;
      w = n + r - 1;
      if (!act) return s;
      s.st   = (u < total) ? 2'd1 : (u < total + m + r - 1) ? 2'd2 : 2'd3;
      s.busy = (u < total + m + r - 1);
      s.done = (u == total + m + r - 1);
      if (u < total) begin
         kr = u % n;
         kc = (u / n) % n;
         kv = u / (n * n);
         s.valid = 1'b1;
         s.rb    = 32'(kr * n + kc);
         s.sw1   = 32'((kv + kr) * w + kc);
         s.sw2   = 32'((kv + kr) * w + kc + r - 1);
         s.vv    = 32'(kv);
         s.pend  = (kr == n - 1) && (kc == n - 1);
         for (int j = 0; j < r; j++) s.mux[j] = !(kr < j);
      end
      for (int j = 0; j < r; j++) s.pe[j] = (u - m - j >= 0) && (u - m - j < total);
      return s;
   endfunction

   // Returns 1 when a stall actually froze an active search.
   function automatic bit adv(input int last_u, input bit start, input bit stall,
                              input bit abort, inout bit act, inout int u);
      bit held;
      held = 1'b0;
      if (!act) begin
         if (start) begin act = 1'b1; u = 0; end
      end else if (abort)                  act = 1'b0;
      else if (stall && (u < last_u))      held = 1'b1;
      else if (u == last_u)                act = 1'b0;
      else                                 u++;
      return held;
   endfunction

   task automatic chk_snap(input string tag, input snap_t obs, input snap_t exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d u=%0d observed=%h expected=%h", tag, cyc, u16, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      void'(adv(LAST16, bus16.in_start, bus16.in_stall, bus16.in_abort, act16, u16));
      void'(adv(LAST8, bus8.in_start, bus8.in_stall, bus8.in_abort, act8, u8));
      @(negedge clk);
      chk_snap("cyc16", o16, expect_snap(N, R, M, act16, u16));
      chk_snap("cyc8", o8, expect_snap(N8, R8, M8, act8, u8));
      if (o16.done) begin done16_cyc = cyc; done16_cnt++; end
      if (o8.done) done8_cyc = cyc;
      if (o8.valid && (int'(o8.sw2) > max_sw2_8)) max_sw2_8 = int'(o8.sw2);
      if (act16 && (u16 == TOTAL16 - 1)) last_idx_cyc = cyc;
   endtask

   task automatic drive_stall();
      if (act16 && (u16 == 1000) && (dir_left > 0)) begin
         bus16.in_stall = 1'b1;
         dir_left--;
      end else if (act16 && (u16 > 50) && (u16 < 4000) && ((u16 < 990) || (u16 > 1010)) &&
                   ($urandom_range(0, 15) == 0)) begin
         bus16.in_stall = 1'b1;
         rnd_stalls++;
      end else begin
         bus16.in_stall = 1'b0;
      end
   endtask

   task automatic plan_checks();
      if (!act16) return;
      case (u16)
         0:    begin chk_int("i0_rb", o16.rb, 0); chk_int("i0_sw1", o16.sw1, 0);
                     chk_int("i0_sw2", o16.sw2, 15); end
         1:    begin chk_int("i1_rb", o16.rb, 16); chk_int("i1_sw1", o16.sw1, 31);
                     chk_int("i1_sw2", o16.sw2, 46); end
         16:   begin chk_int("i16_rb", o16.rb, 1); chk_int("i16_sw1", o16.sw1, 1);
                     chk_int("i16_mux", o16.mux, 32'h0001); end
         255:  begin chk_int("i255_rb", o16.rb, 255); chk_int("i255_sw1", o16.sw1, 480);
                     chk_int("i255_pend", o16.pend, 1); chk_int("i255_vv", o16.vv, 0); end
         256:  begin chk_int("i256_sw1", o16.sw1, 31); chk_int("i256_vv", o16.vv, 1);
                     chk_int("i256_pend", o16.pend, 0); end
         4095: begin chk_int("i4095_sw1", o16.sw1, 945); chk_int("i4095_sw2", o16.sw2, 960); end
         4096: chk_int("drain_pe0", o16.pe, 32'hFFFF);
         4097: chk_int("drain_pe1", o16.pe, 32'hFFFE);
         4111: chk_int("drain_pe15", o16.pe, 32'h8000);
         default: ;
      endcase
   endtask

   initial begin
      int guard, start_cyc, done_before;
      rst = 1'b1;
      bus16.in_start = 1'b0; bus16.in_stall = 1'b0; bus16.in_abort = 1'b0;
      bus8.in_start  = 1'b0; bus8.in_stall  = 1'b0; bus8.in_abort  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_snap("reset16", o16, '0);
      chk_snap("reset8", o8, '0);
      rst = 1'b0;

      // Run 1: both instances start together; directed and random stalls on 16x16.
      bus16.in_start = 1'b1;
      bus8.in_start  = 1'b1;
      step();
      start_cyc = cyc;
      bus16.in_start = 1'b0;
      bus8.in_start  = 1'b0;
      plan_checks();
      dir_left = 5;
      guard = 0;
      while (act16 && !o16.done && (guard < 6000)) begin
         drive_stall();
         bus16.in_start = (u16 == 500);
         step();
         plan_checks();
         guard++;
      end
      bus16.in_stall = 1'b0;
      bus16.in_start = 1'b0;
      chk_int("run1_done_seen", o16.done, 1);
      chk_int("run1_latency", done16_cyc - start_cyc, LAST16 + 5 + rnd_stalls);
      chk_int("last_to_done", done16_cyc - last_idx_cyc, M + R);
      chk_int("ovr_done_cycles", done8_cyc - start_cyc + 1, 521);
      chk_int("ovr_max_sw2", max_sw2_8, 224);

      // Start during DONE is ignored; the first IDLE cycle accepts it.
      bus16.in_start = 1'b1;
      step();
      chk_int("done_start_ignored", o16.st, 0);
      step();
      bus16.in_start = 1'b0;
      chk_int("restart_valid", o16.valid, 1);

      // Run 2: abort (with stall and start also high) at index 2000.
      guard = 0;
      while (act16 && (u16 != 2000) && (guard < 6000)) begin
         drive_stall();
         step();
         guard++;
      end
      chk_int("abort_reached", u16, 2000);
      done_before = done16_cnt;
      bus16.in_abort = 1'b1;
      bus16.in_stall = 1'b1;
      bus16.in_start = 1'b1;
      step();
      bus16.in_abort = 1'b0;
      bus16.in_stall = 1'b0;
      bus16.in_start = 1'b0;
      chk_snap("abort_idle", o16, '0);
      repeat (40) step();
      chk_int("abort_no_done", done16_cnt, done_before);

      // Run 3: asynchronous reset in the middle of RUN.
      bus16.in_start = 1'b1;
      step();
      bus16.in_start = 1'b0;
      repeat (300) begin drive_stall(); step(); end
      bus16.in_stall = 1'b0;
      #2 rst = 1'b1;
      act16 = 1'b0;
      act8  = 1'b0;
      #1;
      chk_snap("async_reset", o16, '0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
